// File: rtl/fsm_control_pcie.sv
// Control FSM for the transaction-layer datapath: sequences RESET/INIT/IDLE/ACTIVE/ERROR,
// owns the FIFO almost-full/almost-empty thresholds and the sticky per-FIFO error record.
module fsm_control_pcie #(
   parameter int                   NFIFO       = 8,
   parameter int                   UMBRAL_W    = 3,
   parameter logic [UMBRAL_W-1:0]  UMB_SUP_RST = 3'b110,
   parameter logic [UMBRAL_W-1:0]  UMB_INF_RST = 3'b001
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [UMBRAL_W-1:0] umbral_superior_in,
   input  logic [UMBRAL_W-1:0] umbral_inferior_in,
   input  logic [NFIFO-1:0]    fifo_empty,
   input  logic [NFIFO-1:0]    fifo_error,
   output logic [3:0]          state,
   output logic [UMBRAL_W-1:0] umbral_superior,
   output logic [UMBRAL_W-1:0] umbral_inferior,
   output logic                idle,
   output logic                cfg_err,
   output logic [NFIFO-1:0]    error_out
);

   typedef enum logic [3:0] {
      S_RESET  = 4'b0001,
      S_INIT   = 4'b0010,
      S_IDLE   = 4'b0100,
      S_ACTIVE = 4'b1000,
      S_ERROR  = 4'b1111
   } state_e;

   state_e              state_q, state_d;
   logic [UMBRAL_W-1:0] umb_sup_q, umb_sup_d;
   logic [UMBRAL_W-1:0] umb_inf_q, umb_inf_d;
   logic                idle_q, cfg_err_q, cfg_err_d;
   logic [NFIFO-1:0]    error_q, error_d;

   logic in_pair_valid;
   logic reg_pair_valid;
   logic any_error;
   logic all_empty;

   assign in_pair_valid  = umbral_inferior_in < umbral_superior_in;
   assign reg_pair_valid = umb_inf_q < umb_sup_q;
   assign any_error      = |fifo_error;
   assign all_empty      = &fifo_empty;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = S_RESET;
      umb_sup_d = umb_sup_q;
      umb_inf_d = umb_inf_q;
      error_d   = error_q;

      case (state_q)
         S_RESET:  state_d = S_INIT;
         S_INIT: begin
            if (!init && reg_pair_valid) state_d = S_IDLE;
            else                         state_d = S_INIT;
         end
         S_IDLE: begin
            if (init)            state_d = S_INIT;
            else if (any_error)  state_d = S_ERROR;
            else if (!all_empty) state_d = S_ACTIVE;
            else                 state_d = S_IDLE;
         end
         S_ACTIVE: begin
            if (any_error)      state_d = S_ERROR;
            else if (init)      state_d = S_INIT;
            else if (all_empty) state_d = S_IDLE;
            else                state_d = S_ACTIVE;
         end
         S_ERROR:  state_d = S_ERROR;
         // Illegal encodings (X, upset) fall back to RESET.
         default:  state_d = S_RESET;
      endcase

      if (state_q == S_INIT && in_pair_valid) begin
         umb_sup_d = umbral_superior_in;
         umb_inf_d = umbral_inferior_in;
      end

      if (state_q == S_IDLE || state_q == S_ACTIVE || state_q == S_ERROR)
         error_d = error_q | fifo_error;

      // Flag only while remaining in INIT, so cfg_err never outlives the INIT state.
      cfg_err_d = (state_q == S_INIT) && (state_d == S_INIT) && !in_pair_valid;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RESET;
         umb_sup_q <= UMB_SUP_RST;
         umb_inf_q <= UMB_INF_RST;
         idle_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         error_q   <= '0;
      end else begin
         state_q   <= state_d;
         umb_sup_q <= umb_sup_d;
         umb_inf_q <= umb_inf_d;
         idle_q    <= (state_d == S_IDLE);
         cfg_err_q <= cfg_err_d;
         error_q   <= error_d;
      end
   end

   assign state           = state_q;
   assign umbral_superior = umb_sup_q;
   assign umbral_inferior = umb_inf_q;
   assign idle            = idle_q;
   assign cfg_err         = cfg_err_q;
   assign error_out       = error_q;

endmodule

// File: tb/tb_fsm_control_pcie.sv
// Table-driven bench for fsm_control_pcie: vectors feed a scoreboard queue that is
// popped and compared one clock later, plus bounded hand-written sequences.
module tb_fsm_control_pcie;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] sup_in, inf_in;
   logic [7:0] fifo_empty, fifo_error;
   logic [3:0] state;
   logic [2:0] umb_sup, umb_inf;
   logic       idle, cfg_err;
   logic [7:0] error_out;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] RST = 4'b0001, INI = 4'b0010, IDL = 4'b0100,
                          ACT = 4'b1000, ERR = 4'b1111;

   typedef struct {
      logic       rst;
      logic       ini;
      logic [2:0] sup;
      logic [2:0] inf;
      logic [7:0] emp;
      logic [7:0] err;
      logic [3:0] e_state;
      logic [2:0] e_sup;
      logic [2:0] e_inf;
      logic       e_idle;
      logic       e_cfg;
      logic [7:0] e_err;
   } vec_t;

   typedef struct {
      logic [3:0] e_state;
      logic [2:0] e_sup;
      logic [2:0] e_inf;
      logic       e_idle;
      logic       e_cfg;
      logic [7:0] e_err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   fsm_control_pcie dut (
      .clk                (clk),
      .reset              (reset),
      .init               (init),
      .umbral_superior_in (sup_in),
      .umbral_inferior_in (inf_in),
      .fifo_empty         (fifo_empty),
      .fifo_error         (fifo_error),
      .state              (state),
      .umbral_superior    (umb_sup),
      .umbral_inferior    (umb_inf),
      .idle               (idle),
      .cfg_err            (cfg_err),
      .error_out          (error_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic ini, input logic [2:0] sup,
                               input logic [2:0] inf, input logic [7:0] emp, input logic [7:0] err,
                               input logic [3:0] es, input logic [2:0] esup, input logic [2:0] einf,
                               input logic eidle, input logic ecfg, input logic [7:0] eerr);
      vec_t v;
      v.rst = rst; v.ini = ini; v.sup = sup; v.inf = inf; v.emp = emp; v.err = err;
      v.e_state = es; v.e_sup = esup; v.e_inf = einf; v.e_idle = eidle; v.e_cfg = ecfg; v.e_err = eerr;
      return v;
   endfunction

   // Drive one vector on the falling edge, queue its expectation, compare after the rising edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t e, got;
      @(negedge clk);
      reset = v.rst; init = v.ini; sup_in = v.sup; inf_in = v.inf;
      fifo_empty = v.emp; fifo_error = v.err;
      e.e_state = v.e_state; e.e_sup = v.e_sup; e.e_inf = v.e_inf;
      e.e_idle = v.e_idle; e.e_cfg = v.e_cfg; e.e_err = v.e_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check($sformatf("v%0d state", idx),     {12'd0, state},     {12'd0, got.e_state});
      check($sformatf("v%0d umb_sup", idx),   {13'd0, umb_sup},   {13'd0, got.e_sup});
      check($sformatf("v%0d umb_inf", idx),   {13'd0, umb_inf},   {13'd0, got.e_inf});
      check($sformatf("v%0d idle", idx),      {15'd0, idle},      {15'd0, got.e_idle});
      check($sformatf("v%0d cfg_err", idx),   {15'd0, cfg_err},   {15'd0, got.e_cfg});
      check($sformatf("v%0d error_out", idx), {8'd0, error_out},  {8'd0, got.e_err});
   endtask

   initial begin
      int cyc;
      reset = 1'b1; init = 1'b0; sup_in = 3'b110; inf_in = 3'b001;
      fifo_empty = 8'hFF; fifo_error = 8'h00;

      //            rst ini sup     inf     emp    err     state sup     inf     idl cfg err
      vecs.push_back(mk(1, 0, 3'b110, 3'b001, 8'hFF, 8'h00, RST, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 3'b110, 3'b001, 8'hFF, 8'h00, RST, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b110, 3'b001, 8'hFF, 8'h00, INI, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 3'b101, 3'b010, 8'hFF, 8'h00, INI, 3'b101, 3'b010, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b101, 3'b010, 8'hFF, 8'h00, IDL, 3'b101, 3'b010, 1, 0, 8'h00));
      // invalid pair: thresholds hold, cfg_err raised while still in INIT
      vecs.push_back(mk(0, 1, 3'b010, 3'b011, 8'hFF, 8'h00, INI, 3'b101, 3'b010, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 3'b010, 3'b011, 8'hFF, 8'h00, INI, 3'b101, 3'b010, 0, 1, 8'h00));
      vecs.push_back(mk(0, 0, 3'b010, 3'b011, 8'hFF, 8'h00, IDL, 3'b101, 3'b010, 1, 0, 8'h00));
      // traffic, thresholds frozen outside INIT
      vecs.push_back(mk(0, 0, 3'b010, 3'b011, 8'hFE, 8'h00, ACT, 3'b101, 3'b010, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b111, 3'b000, 8'hFE, 8'h00, ACT, 3'b101, 3'b010, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b111, 3'b000, 8'hFF, 8'h00, IDL, 3'b101, 3'b010, 1, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b111, 3'b000, 8'hFE, 8'h00, ACT, 3'b101, 3'b010, 0, 0, 8'h00));
      // error + init in ACTIVE -> ERROR, sticky accumulation
      vecs.push_back(mk(0, 1, 3'b111, 3'b000, 8'hFE, 8'h20, ERR, 3'b101, 3'b010, 0, 0, 8'h20));
      vecs.push_back(mk(0, 0, 3'b111, 3'b000, 8'hFE, 8'h01, ERR, 3'b101, 3'b010, 0, 0, 8'h21));
      vecs.push_back(mk(0, 0, 3'b111, 3'b000, 8'hFF, 8'h00, ERR, 3'b101, 3'b010, 0, 0, 8'h21));
      vecs.push_back(mk(0, 1, 3'b111, 3'b000, 8'hFF, 8'h00, ERR, 3'b101, 3'b010, 0, 0, 8'h21));
      vecs.push_back(mk(1, 0, 3'b111, 3'b000, 8'hFF, 8'h00, RST, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b111, 3'b011, 8'hFF, 8'h00, INI, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b111, 3'b011, 8'hFF, 8'h00, IDL, 3'b111, 3'b011, 1, 0, 8'h00));
      // error in IDLE without init -> ERROR
      vecs.push_back(mk(0, 0, 3'b111, 3'b011, 8'hFF, 8'h04, ERR, 3'b111, 3'b011, 0, 0, 8'h04));
      vecs.push_back(mk(1, 0, 3'b111, 3'b011, 8'hFF, 8'h00, RST, 3'b110, 3'b001, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b100, 3'b000, 8'hFF, 8'h00, INI, 3'b110, 3'b001, 0, 0, 8'h00));
      // error during INIT ignored
      vecs.push_back(mk(0, 1, 3'b100, 3'b000, 8'hFF, 8'hFF, INI, 3'b100, 3'b000, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 3'b100, 3'b000, 8'hFF, 8'h00, IDL, 3'b100, 3'b000, 1, 0, 8'h00));
      // error + init in IDLE -> INIT, error still recorded
      vecs.push_back(mk(0, 1, 3'b100, 3'b000, 8'hFF, 8'h02, INI, 3'b100, 3'b000, 0, 0, 8'h02));
      vecs.push_back(mk(0, 0, 3'b101, 3'b100, 8'hFF, 8'h00, IDL, 3'b101, 3'b100, 1, 0, 8'h02));
      vecs.push_back(mk(0, 0, 3'b101, 3'b100, 8'h7F, 8'h00, ACT, 3'b101, 3'b100, 0, 0, 8'h02));
      // init from ACTIVE, then equal pair is invalid
      vecs.push_back(mk(0, 1, 3'b011, 3'b011, 8'h7F, 8'h00, INI, 3'b101, 3'b100, 0, 0, 8'h02));
      vecs.push_back(mk(0, 1, 3'b011, 3'b011, 8'h7F, 8'h00, INI, 3'b101, 3'b100, 0, 1, 8'h02));
      vecs.push_back(mk(0, 0, 3'b101, 3'b100, 8'hFF, 8'h00, IDL, 3'b101, 3'b100, 1, 0, 8'h02));
      vecs.push_back(mk(0, 0, 3'b101, 3'b100, 8'h0F, 8'h00, ACT, 3'b101, 3'b100, 0, 0, 8'h02));
      // any single non-empty FIFO keeps ACTIVE
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 3'b101, 3'b100, ~(8'h01 << i), 8'h00, ACT, 3'b101, 3'b100, 0, 0, 8'h02));
      // mid-ACTIVE reset restores defaults
      vecs.push_back(mk(1, 1, 3'b101, 3'b100, 8'h0F, 8'h10, RST, 3'b110, 3'b001, 0, 0, 8'h00));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Hand sequence: from reset with init low, idle must appear exactly two clocks later.
      @(negedge clk);
      reset = 1'b0; init = 1'b0; sup_in = 3'b110; inf_in = 3'b001;
      fifo_empty = 8'hFF; fifo_error = 8'h00;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
         if (idle) break;
      end
      check("reset_to_idle_cycles", 16'(cyc), 16'd2);
      check("reset_to_idle_state", {12'd0, state}, {12'd0, IDL});

      // Hand sequence: ERROR must persist across many quiet cycles until reset.
      @(negedge clk);
      fifo_error = 8'h80;
      @(negedge clk);
      fifo_error = 8'h00;
      init = 1'b1;
      repeat (5) @(negedge clk);
      check("error_persist_state", {12'd0, state}, {12'd0, ERR});
      check("error_persist_bits", {8'd0, error_out}, 16'h0080);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("error_exit_state", {12'd0, state}, {12'd0, RST});
      check("error_exit_bits", {8'd0, error_out}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
